// File: rtl/online_softmax_pkg.sv
// Shared types, constants and the exp lookup table for the online-softmax stage.
package online_softmax_pkg;

  localparam int unsigned SCORE_W    = 32;
  localparam int unsigned SCORE_FRAC = 4;
  localparam int unsigned EXP_FRAC   = 15;
  localparam int unsigned EXP_W      = EXP_FRAC + 1;
  localparam int unsigned LUT_AW     = 8;
  localparam int unsigned LUT_DEPTH  = 1 << LUT_AW;
  localparam int unsigned SUM_W      = 32;
  localparam int unsigned DIFF_W     = SCORE_W + 1;

  typedef logic signed [SCORE_W-1:0] INT_T;
  typedef logic [EXP_W-1:0]          EXP_T;
  typedef logic [SUM_W-1:0]          SUM_T;
  typedef logic [DIFF_W-1:0]         DIFF_T;
  typedef EXP_T [LUT_DEPTH-1:0]      LUT_T;

  typedef struct packed {
    logic  vld;
    logic  first;
    logic  last;
    logic  alpha_zero;
    DIFF_T d_s;
    DIFF_T d_m;
  } s1_t;

  // round(2^EXP_FRAC * exp(-i / 2^SCORE_FRAC)); the top entry is 0 so saturated differences vanish.
  function automatic LUT_T gen_exp_lut();
    LUT_T t;
    real  v;
    for (int unsigned i = 0; i < LUT_DEPTH; i++) begin
      v = (2.0 ** EXP_FRAC) * $exp(-real'(i) / (2.0 ** SCORE_FRAC));
      t[LUT_AW'(i)] = EXP_W'($rtoi(v + 0.5));
    end
    t[LUT_DEPTH-1] = '0;
    return t;
  endfunction

  localparam LUT_T EXP_LUT = gen_exp_lut();

endpackage

// File: rtl/online_softmax_if.sv
// Score stream in, weight/rescale/denominator stream out, with valid/ready.
interface online_softmax_if;
  import online_softmax_pkg::*;

  logic vld_in;
  logic rdy_in;
  logic vld_out;
  logic rdy_out;
  INT_T s_in;
  logic last_in;
  EXP_T p_out;
  EXP_T alpha_out;
  SUM_T l_out;
  logic last_out;

  modport slave (
    input  vld_in, rdy_in, s_in, last_in,
    output vld_out, rdy_out, p_out, alpha_out, l_out, last_out
  );

  modport master (
    output vld_in, rdy_in, s_in, last_in,
    input  vld_out, rdy_out, p_out, alpha_out, l_out, last_out
  );
endinterface

// File: rtl/online_softmax_exp_lut.sv
// Combinational exp(-d) ROM; any difference beyond the table reads the last (zero) entry.
module exp_lut
  import online_softmax_pkg::*;
(
  input  DIFF_T idx,
  output EXP_T  val
);

  logic [LUT_AW-1:0] addr;

  always_comb begin
    addr = '1;
    if (idx < DIFF_W'(LUT_DEPTH - 1))
      addr = idx[LUT_AW-1:0];
    val = EXP_LUT[addr];
  end

endmodule

// File: rtl/online_softmax.sv
// Two-stage online softmax: stage 1 tracks the running max, stage 2 looks up
// p/alpha and rescales the running denominator.
module online_softmax
  import online_softmax_pkg::*;
(
  input logic            clk,
  input logic            rst,
  online_softmax_if.slave bus
);

  localparam int unsigned PROD_W = SUM_W + EXP_W;

  INT_T  m;
  logic  first;
  s1_t   s1;

  logic  accept;
  INT_T  m_new;
  DIFF_T d_s_c;
  DIFF_T d_m_c;

  EXP_T  p_v;
  EXP_T  a_lut;
  EXP_T  alpha_v;
  SUM_T  l;
  SUM_T  l_new;
  logic [PROD_W-1:0]  prod;
  logic [SUM_W+1:0]   acc;

  assign bus.rdy_out = bus.rdy_in;

  always_comb begin
    accept = bus.vld_in & bus.rdy_in;
    m_new  = bus.s_in;
    d_m_c  = '0;
    if (!first) begin
      m_new = (bus.s_in > m) ? bus.s_in : m;
      d_m_c = DIFF_W'(m_new) - DIFF_W'(m);
    end
    d_s_c = DIFF_W'(m_new) - DIFF_W'(bus.s_in);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1    <= '0;
      m     <= '0;
      first <= 1'b1;
    end else if (bus.rdy_in) begin
      s1.vld <= accept;
      if (accept) begin
        s1.first      <= first;
        s1.last       <= bus.last_in;
        s1.alpha_zero <= first;
        s1.d_s        <= d_s_c;
        s1.d_m        <= d_m_c;
        m             <= m_new;
        first         <= bus.last_in;
      end
    end
  end

  exp_lut u_p_lut (
    .idx (s1.d_s),
    .val (p_v)
  );

  exp_lut u_alpha_lut (
    .idx (s1.d_m),
    .val (a_lut)
  );

  // l is rescaled by alpha before adding p; the carry bits above SUM_W flag saturation.
  always_comb begin
    alpha_v = s1.alpha_zero ? '0 : a_lut;
    prod    = PROD_W'(l) * PROD_W'(alpha_v);
    acc     = (SUM_W + 2)'(prod >> EXP_FRAC) + (SUM_W + 2)'(p_v);
    if (s1.first)
      l_new = SUM_W'(p_v);
    else if (|acc[SUM_W+1:SUM_W])
      l_new = '1;
    else
      l_new = acc[SUM_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.vld_out   <= 1'b0;
      bus.p_out     <= '0;
      bus.alpha_out <= '0;
      bus.l_out     <= '0;
      bus.last_out  <= 1'b0;
      l             <= '0;
    end else if (bus.rdy_in) begin
      bus.vld_out  <= s1.vld;
      bus.last_out <= s1.vld & s1.last;
      if (s1.vld) begin
        bus.p_out     <= p_v;
        bus.alpha_out <= alpha_v;
        bus.l_out     <= l_new;
        l             <= l_new;
      end
    end
  end

endmodule

// File: tb/tb_online_softmax.sv
// Directed checks of the online-softmax stage against hand-computed results.
module tb_online_softmax;
  import online_softmax_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  online_softmax_if bus ();

  online_softmax dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp_v);
    n_total++;
    if (act !== exp_v)
      $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int s, input logic last);
    bus.vld_in  = v;
    bus.s_in    = INT_T'(s);
    bus.last_in = last;
  endtask

  task automatic expect_out(input string tag, input int p, input int a, input longint l,
                            input logic last);
    chk({tag, ".vld"},   64'(bus.vld_out),   64'd1);
    chk({tag, ".p"},     64'(bus.p_out),     64'(p));
    chk({tag, ".alpha"}, 64'(bus.alpha_out), 64'(a));
    chk({tag, ".l"},     64'(bus.l_out),     64'(l));
    chk({tag, ".last"},  64'(bus.last_out),  64'(last));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got 0 expected 1 (simulation did not finish)");
    $fatal(1, "timeout");
  end

  initial begin
    bus.rdy_in = 1'b1;
    drive(1'b0, 0, 1'b0);
    #12;
    chk("rst.vld",   64'(bus.vld_out),   64'd0);
    chk("rst.p",     64'(bus.p_out),     64'd0);
    chk("rst.alpha", 64'(bus.alpha_out), 64'd0);
    chk("rst.l",     64'(bus.l_out),     64'd0);
    chk("rst.last",  64'(bus.last_out),  64'd0);
    rst = 1'b1;
    tick();
    chk("rdy_pass1", 64'(bus.rdy_out), 64'd1);
    bus.rdy_in = 1'b0;
    #1;
    chk("rdy_pass0", 64'(bus.rdy_out), 64'd0);
    bus.rdy_in = 1'b1;

    // Single-score row
    drive(1'b1, 100, 1'b1);
    tick();
    drive(1'b0, 0, 1'b0);
    chk("single.lat1", 64'(bus.vld_out), 64'd0);
    tick();
    expect_out("single", 32768, 0, 32768, 1'b1);
    tick();
    chk("single.bubble", 64'(bus.vld_out), 64'd0);

    // Row 0,16,0
    drive(1'b1, 0, 1'b0);  tick();
    drive(1'b1, 16, 1'b0); tick();
    expect_out("row3.0", 32768, 0, 32768, 1'b0);
    drive(1'b1, 0, 1'b1);  tick();
    expect_out("row3.1", 32768, 12055, 44823, 1'b0);
    drive(1'b0, 0, 1'b0);  tick();
    expect_out("row3.2", 12055, 32768, 56878, 1'b1);
    tick();
    chk("row3.bubble", 64'(bus.vld_out), 64'd0);

    // Negative scores: max tracking must be signed
    drive(1'b1, -32, 1'b0); tick();
    drive(1'b1, -16, 1'b1); tick();
    expect_out("neg.0", 32768, 0, 32768, 1'b0);
    drive(1'b0, 0, 1'b0);   tick();
    expect_out("neg.1", 32768, 12055, 44823, 1'b1);

    // Saturated difference
    drive(1'b1, 0, 1'b0);     tick();
    drive(1'b1, 10000, 1'b1); tick();
    expect_out("sat.0", 32768, 0, 32768, 1'b0);
    drive(1'b0, 0, 1'b0);     tick();
    expect_out("sat.1", 32768, 0, 32768, 1'b1);

    // Backpressure mid-row: 0,16,0 with a 3-cycle stall before the last score
    drive(1'b1, 0, 1'b0);  tick();
    drive(1'b1, 16, 1'b0); tick();
    drive(1'b1, 0, 1'b1);
    bus.rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_out($sformatf("stall%0d", i), 32768, 0, 32768, 1'b0);
      chk($sformatf("stall%0d.m", i), 64'(dut.m), 64'd16);
    end
    bus.rdy_in = 1'b1;
    tick();
    expect_out("resume.1", 32768, 12055, 44823, 1'b0);
    drive(1'b0, 0, 1'b0); tick();
    expect_out("resume.2", 12055, 32768, 56878, 1'b1);

    // Back-to-back single-score rows
    drive(1'b1, 16, 1'b1); tick();
    drive(1'b1, 0, 1'b1);  tick();
    expect_out("b2b.0", 32768, 0, 32768, 1'b1);
    drive(1'b0, 0, 1'b0);  tick();
    expect_out("b2b.1", 32768, 0, 32768, 1'b1);

    // Reset mid-row discards the partial row
    drive(1'b1, 0, 1'b0);  tick();
    drive(1'b1, 16, 1'b0); tick();
    drive(1'b0, 0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst.vld", 64'(bus.vld_out), 64'd0);
    chk("midrst.l",   64'(bus.l_out),   64'd0);
    tick();
    #2;
    rst = 1'b1;
    tick();
    drive(1'b1, 5, 1'b1); tick();
    drive(1'b0, 0, 1'b0); tick();
    expect_out("postrst", 32768, 0, 32768, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/online_softmax.md
Name: online_softmax

Overview:
- Streaming online-softmax stage directly downstream of dot_product. It consumes one scaled score s per cycle for a query row and tracks the running max m and running denominator l.
- Per score it emits the unnormalised weight p = exp(s - m_new) and the rescale factor alpha = exp(m_old - m_new). The PV accumulator applies alpha to its partial output, then adds p*V.
- On the last score of a row it also emits the final denominator l.

Parameters:
- SCORE_W, 32: score width; signed fixed point (INT_T).
- SCORE_FRAC, 4: fractional bits of the score; 16 = 1.0.
- EXP_FRAC, 15: fractional bits of p and alpha; unsigned Q1.15 in 16 bits; 1.0 = 32768.
- LUT_AW, 8: exp LUT address width; 256 entries.
- SUM_W, 32: width of l; unsigned, EXP_FRAC fractional bits.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- vld_in  in  1  upstream valid (from dot_product vld_out)
- rdy_in  in  1  downstream ready
- vld_out  out  1  outputs valid this cycle
- rdy_out  out  1  ready to accept input
- s_in  in  SCORE_W  score
- last_in  in  1  s_in is the final key of the row
- p_out  out  EXP_FRAC+1  exp(s - m_new)
- alpha_out  out  EXP_FRAC+1  exp(m_old - m_new)
- l_out  out  SUM_W  running denominator including this p
- last_out  out  1  qualifies l_out as the final row sum

Behaviour:
- Reset (rst=0, asynchronous):
  - All outputs 0.
  - Pipeline valid bits cleared.
  - m = 0, l = 0, first flag = 1.
  - Reset mid-row discards the partial row; the next accepted score starts a new row.
- Handshake:
  - rdy_out = rdy_in (combinational).
  - Accept when vld_in && rdy_in.
  - Both pipeline stages advance only when rdy_in=1. When rdy_in=0, all registers, m and l hold.
  - A stage with no valid data advancing produces a bubble (valid=0).
- Latency: 2 cycles from accept to vld_out.
- Stage 1 (on accept):
  - If first: m_new = s, alpha_zero = 1, d_m = 0.
  - Else: m_new = max(m, s); d_m = m_new - m.
  - d_s = m_new - s.
  - Both differences are non-negative. Each saturates to 2^LUT_AW - 1.
  - Register m <= m_new.
  - first <= last_in, so the row after a last_in starts fresh.
  - Propagate last and first to stage 2.
- Stage 2:
  - p = LUT[d_s].
  - alpha = 0 if alpha_zero, else LUT[d_m].
  - If first: l_new = p. Else: l_new = ((l * alpha) >> EXP_FRAC) + p, truncated; saturate at 2^SUM_W - 1.
  - Register p_out, alpha_out, l_out = l_new, last_out, vld_out.
  - l <= l_new.
- LUT:
  - LUT[i] = round(2^EXP_FRAC * exp(-i / 2^SCORE_FRAC)); LUT[0] = 32768.
  - LUT[255] is forced to 0; saturated differences therefore give exactly 0.
- Single-element row (first and last together): alpha=0, p=32768, l=32768, last_out=1.
- Back-to-back rows with no gap are supported.
- vld_in=1 while rdy_in=0: input is not consumed, and upstream holds it.

Decomposition:
- Shared package gets:
  - INT_T
  - EXP_T (16-bit unsigned Q1.15)
  - SUM_T
  - constants SCORE_FRAC, EXP_FRAC, LUT_AW
  - function-generated LUT contents constant EXP_LUT
- One sub-module, exp_lut: combinational 256x16 ROM with saturating index. It is instantiated twice, for p and alpha.

Test Plan:
- Single-score row, s=100, last=1 -> after 2 cycles: p=32768, alpha=0, l=32768, last_out=1.
- Row s=0,16,0 (last on third) -> outputs in order:
  - (p=32768, alpha=0, l=32768)
  - (p=32768, alpha=12055, l=44823)
  - (p=12055, alpha=32768, l=56878, last_out=1)
- Saturation: row s=0 then s=10000 -> second output p=32768, alpha=0 (d_m saturated, LUT[255]=0), l=32768.
- Backpressure: hold rdy_in=0 for 3 cycles mid-row -> vld_out, p_out, l_out and m are unchanged. Resume gives results identical to the unstalled run.
- Back-to-back rows: [16, last], [0, last] consecutively -> second row reports alpha=0, p=32768, l=32768 (no carry-over of m=16).
- Reset mid-row after s=0,16 -> deassert, send s=5 last -> p=32768, alpha=0, l=32768, last_out=1.
